// File: rtl/line_engine.sv
// Bresenham line engine: draws a line into a 1024x1024 32-bit frame buffer by
// issuing one DDR burst (one address push plus two 128-bit data beats) per pixel.
//
// Handshake: the engine accepts coordinate/colour strobes and LE_trigger only
// while LE_ready is high (IDLE). Toward the memory FIFOs it pushes only when the
// matching full flag is low. af_wr_en never fires without wdf_wr_en in the same
// cycle. A beat is held, with its write enable low, for as long as the FIFO
// reports full.
module line_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  LE_color,
  input  logic [9:0]   LE_point,
  input  logic         LE_color_valid,
  input  logic         LE_x0_valid,
  input  logic         LE_y0_valid,
  input  logic         LE_x1_valid,
  input  logic         LE_y1_valid,
  input  logic         LE_trigger,
  input  logic [31:0]  LE_frame_base,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic         LE_ready,
  output logic [30:0]  af_addr_din,
  output logic         af_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;
  localparam logic [1:0] S_BEAT2 = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] color_q, color_d;
  logic [9:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic        steep_q, steep_d;
  logic        yup_q, yup_d;
  logic [9:0]  cx_q, cx_d, cy_q, cy_d, xend_q, xend_d;
  logic [9:0]  dx_q, dx_d, dy_q, dy_d;
  logic [11:0] err_q, err_d;   // two's complement, bit 11 is the sign

  // Line setup terms derived from the loaded endpoints
  logic [10:0] ddx, ddy, adx, ady;
  logic        steep_c, swap_c, yup_c;
  logic [9:0]  sx0, sy0, sx1, sy1;
  logic [9:0]  ex0, ey0, ex1, ey1;
  logic [9:0]  dx_c, dy_c;

  // Per-step error update
  logic [11:0] err_sub, err_new;
  logic [9:0]  cy_step;

  // Current pixel in frame coordinates
  logic [9:0]  px, py;
  logic [15:0] pix_mask;
  logic        push_beat1, push_beat2;

  logic        unused_base;
  assign unused_base = ^LE_frame_base[21:0];

  // Endpoint normalisation: make the line shallow and left-to-right
  always_comb begin
    ddx     = {1'b0, x1_q} - {1'b0, x0_q};
    ddy     = {1'b0, y1_q} - {1'b0, y0_q};
    adx     = ddx[10] ? (11'd0 - ddx) : ddx;
    ady     = ddy[10] ? (11'd0 - ddy) : ddy;
    steep_c = ady > adx;
    sx0     = steep_c ? y0_q : x0_q;
    sy0     = steep_c ? x0_q : y0_q;
    sx1     = steep_c ? y1_q : x1_q;
    sy1     = steep_c ? x1_q : y1_q;
    swap_c  = sx0 > sx1;
    ex0     = swap_c ? sx1 : sx0;
    ey0     = swap_c ? sy1 : sy0;
    ex1     = swap_c ? sx0 : sx1;
    ey1     = swap_c ? sy0 : sy1;
    dx_c    = ex1 - ex0;
    dy_c    = (ey1 > ey0) ? (ey1 - ey0) : (ey0 - ey1);
    yup_c   = ey0 < ey1;
  end

  // Bresenham step: subtract dy, and on underflow move one row and add dx back
  always_comb begin
    err_sub = err_q - {2'b00, dy_q};
    err_new = err_sub;
    cy_step = cy_q;
    if (err_sub[11]) begin
      err_new = err_sub + {2'b00, dx_q};
      cy_step = yup_q ? (cy_q + 10'd1) : (cy_q - 10'd1);
    end
  end

  // FSM and datapath next-state
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    steep_d = steep_q;
    yup_d   = yup_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    xend_d  = xend_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (LE_color_valid) color_d = LE_color;
        if (LE_x0_valid)    x0_d    = LE_point;
        if (LE_y0_valid)    y0_d    = LE_point;
        if (LE_x1_valid)    x1_d    = LE_point;
        if (LE_y1_valid)    y1_d    = LE_point;
        if (LE_trigger)     state_d = S_SETUP;
      end
      S_SETUP: begin
        steep_d = steep_c;
        yup_d   = yup_c;
        cx_d    = ex0;
        cy_d    = ey0;
        xend_d  = ex1;
        dx_d    = dx_c;
        dy_d    = dy_c;
        err_d   = {3'b000, dx_c[9:1]};
        state_d = S_BEAT1;
      end
      S_BEAT1: begin
        if (!af_full && !wdf_full) state_d = S_BEAT2;
      end
      S_BEAT2: begin
        if (!wdf_full) begin
          if (cx_q == xend_q) begin
            state_d = S_IDLE;
          end else begin
            cx_d    = cx_q + 10'd1;
            cy_d    = cy_step;
            err_d   = err_new;
            state_d = S_BEAT1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      color_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      steep_q <= 1'b0;
      yup_q   <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      xend_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      steep_q <= steep_d;
      yup_q   <= yup_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xend_q  <= xend_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
    end
  end

  // FIFO pushes, burst address and byte mask for the current pixel
  always_comb begin
    px           = steep_q ? cy_q : cx_q;
    py           = steep_q ? cx_q : cy_q;
    push_beat1   = (state_q == S_BEAT1) && !af_full && !wdf_full;
    push_beat2   = (state_q == S_BEAT2) && !wdf_full;
    LE_ready     = (state_q == S_IDLE);
    af_wr_en     = push_beat1;
    wdf_wr_en    = push_beat1 || push_beat2;
    af_addr_din  = {2'b00, LE_frame_base[31:22], py, px[9:3], 2'b00};
    wdf_din      = {4{color_q}};
    // lane k occupies mask bits [15-4k -: 4]; clear that nibble to write it
    pix_mask     = ~(16'hF000 >> {px[1:0], 2'b00});
    wdf_mask_din = 16'hFFFF;
    if (((state_q == S_BEAT1) && !px[2]) || ((state_q == S_BEAT2) && px[2]))
      wdf_mask_din = pix_mask;
  end

endmodule

// File: tb/tb_line_engine.sv
// Bench for line_engine: random and directed lines against an integer
// Bresenham reference model, with FIFO backpressure and reset abort.
module tb_line_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  LE_color = '0;
  logic [9:0]   LE_point = '0;
  logic         LE_color_valid = 1'b0;
  logic         LE_x0_valid = 1'b0;
  logic         LE_y0_valid = 1'b0;
  logic         LE_x1_valid = 1'b0;
  logic         LE_y1_valid = 1'b0;
  logic         LE_trigger = 1'b0;
  logic [31:0]  LE_frame_base = '0;
  logic         af_full = 1'b0;
  logic         wdf_full = 1'b0;
  logic         LE_ready;
  logic [30:0]  af_addr_din;
  logic         af_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic         wdf_wr_en;

  line_engine dut (
    .clk            (clk),
    .rst            (rst),
    .LE_color       (LE_color),
    .LE_point       (LE_point),
    .LE_color_valid (LE_color_valid),
    .LE_x0_valid    (LE_x0_valid),
    .LE_y0_valid    (LE_y0_valid),
    .LE_x1_valid    (LE_x1_valid),
    .LE_y1_valid    (LE_y1_valid),
    .LE_trigger     (LE_trigger),
    .LE_frame_base  (LE_frame_base),
    .af_full        (af_full),
    .wdf_full       (wdf_full),
    .LE_ready       (LE_ready),
    .af_addr_din    (af_addr_din),
    .af_wr_en       (af_wr_en),
    .wdf_din        (wdf_din),
    .wdf_mask_din   (wdf_mask_din),
    .wdf_wr_en      (wdf_wr_en)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_af = 0;
  int n_beat = 0;
  logic [30:0]  exp_addr_q[$];
  logic [143:0] exp_beat_q[$];   // {mask, data}

  task automatic check_eq(input string tag, input logic [143:0] act, input logic [143:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected burst for one pixel: address push, then two masked beats
  task automatic plot(input int px, input int py, input logic [31:0] col, input logic [31:0] base);
    logic [31:0] a;
    logic [15:0] m;
    int lane;
    a    = ((base >> 22) << 19) + (py << 9) + ((px / 8) << 2);
    lane = px % 4;
    m    = 16'hFFFF ^ (16'hF << (4 * (3 - lane)));
    exp_addr_q.push_back(a[30:0]);
    exp_beat_q.push_back({((px % 8) < 4) ? m : 16'hFFFF, {4{col}}});
    exp_beat_q.push_back({((px % 8) >= 4) ? m : 16'hFFFF, {4{col}}});
  endtask

  // Reference line: integer Bresenham over the pixel set, in emission order
  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [31:0] col, input logic [31:0] base, output int npix);
    int t, dx, dy, err, ystep, y;
    bit steep;
    steep = iabs(ay1 - ay0) > iabs(ax1 - ax0);
    if (steep) begin
      t = ax0; ax0 = ay0; ay0 = t;
      t = ax1; ax1 = ay1; ay1 = t;
    end
    if (ax0 > ax1) begin
      t = ax0; ax0 = ax1; ax1 = t;
      t = ay0; ay0 = ay1; ay1 = t;
    end
    dx = ax1 - ax0;
    dy = iabs(ay1 - ay0);
    err = dx / 2;
    ystep = (ay0 < ay1) ? 1 : -1;
    y = ay0;
    npix = 0;
    for (int x = ax0; x <= ax1; x++) begin
      if (steep) plot(y, x, col, base);
      else       plot(x, y, col, base);
      npix++;
      err = err - dy;
      if (err < 0) begin
        y = y + ystep;
        err = err + dx;
      end
    end
  endtask

  // Monitor: every FIFO push is matched against the expected queues
  always @(negedge clk) begin
    if (!rst) begin
      if (af_wr_en) begin
        n_af++;
        check_eq("af_with_wdf", wdf_wr_en, 1);
        if (exp_addr_q.size() == 0) check_eq("af_unexpected", af_wr_en, 0);
        else check_eq("af_addr", af_addr_din, exp_addr_q.pop_front());
      end
      if (wdf_wr_en) begin
        n_beat++;
        if (exp_beat_q.size() == 0) check_eq("wdf_unexpected", wdf_wr_en, 0);
        else check_eq("wdf_beat", {wdf_mask_din, wdf_din}, exp_beat_q.pop_front());
      end
      if (af_full)  check_eq("af_push_while_full", af_wr_en, 0);
      if (wdf_full) check_eq("wdf_push_while_full", wdf_wr_en, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    LE_color_valid = 1'b0;
    LE_x0_valid = 1'b0;
    LE_y0_valid = 1'b0;
    LE_x1_valid = 1'b0;
    LE_y1_valid = 1'b0;
    LE_trigger = 1'b0;
  endtask

  // mode: 0 none, 1 random backpressure, 2 af_full 20 cycles, 3 wdf_full 20 cycles,
  //       4 stray strobes/trigger while busy, 5 reset abort after 40 cycles
  task automatic run_line(input bit do_load, input int ax0, input int ay0, input int ax1,
                          input int ay1, input logic [31:0] col, input int mode);
    int npix, cyc, busy;
    bit aborted;
    LE_frame_base = $urandom;
    model_line(ax0, ay0, ax1, ay1, col, LE_frame_base, npix);
    n_af = 0;
    n_beat = 0;
    if (do_load) begin
      LE_color = col; LE_color_valid = 1'b1;
      LE_point = ax0[9:0]; LE_x0_valid = 1'b1; LE_y0_valid = (ax0 == ay0);
      tick(); clr_strobes();
      if (ax0 != ay0) begin
        LE_point = ay0[9:0]; LE_y0_valid = 1'b1;
        tick(); clr_strobes();
      end
      LE_point = ax1[9:0]; LE_x1_valid = 1'b1; LE_y1_valid = (ax1 == ay1);
      tick(); clr_strobes();
      LE_point = ay1[9:0]; LE_y1_valid = 1'b1;
    end
    LE_trigger = 1'b1;
    tick(); clr_strobes();
    cyc = 0; busy = 0; aborted = 0;
    while (1) begin
      if (cyc >= 8000) begin
        check_eq("ready_timeout", LE_ready, 1);
        break;
      end
      case (mode)
        1: begin af_full = ($urandom_range(0, 3) == 0); wdf_full = ($urandom_range(0, 3) == 0); end
        2: af_full = (cyc >= 10 && cyc < 30);
        3: wdf_full = (cyc >= 10 && cyc < 30);
        4: begin
          if (cyc == 5) begin
            LE_point = $urandom; LE_color = $urandom;
            LE_color_valid = 1'b1; LE_x0_valid = 1'b1; LE_y0_valid = 1'b1;
            LE_x1_valid = 1'b1; LE_y1_valid = 1'b1; LE_trigger = 1'b1;
          end else begin
            clr_strobes();
          end
        end
        default: ;
      endcase
      if (mode == 5 && cyc == 40) begin
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_eq("abort_af_wr_en", af_wr_en, 0);
        check_eq("abort_wdf_wr_en", wdf_wr_en, 0);
        check_eq("abort_ready", LE_ready, 1);
        exp_addr_q.delete();
        exp_beat_q.delete();
        rst = 1'b0;
        aborted = 1;
        break;
      end
      @(negedge clk);
      if (LE_ready) break;
      busy++;
      tick();
      cyc++;
    end
    af_full = 1'b0;
    wdf_full = 1'b0;
    clr_strobes();
    if (!aborted) begin
      check_eq("addr_push_count", n_af, npix);
      check_eq("data_beat_count", n_beat, 2 * npix);
      check_eq("addr_left_over", exp_addr_q.size(), 0);
      check_eq("beat_left_over", exp_beat_q.size(), 0);
      if (mode == 0) check_eq("busy_cycles", busy, 2 * npix + 1);
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_ready", LE_ready, 1);
    check_eq("rst_af_wr_en", af_wr_en, 0);
    check_eq("rst_wdf_wr_en", wdf_wr_en, 0);
    check_eq("rst_mask", wdf_mask_din, 16'hFFFF);
    rst = 1'b0;
    tick();

    // registers reset to zero: a bare trigger draws pixel (0,0) in colour 0
    run_line(0, 0, 0, 0, 0, 32'h0, 0);
    run_line(1, 0, 0, 300, 200, 32'h007F0000, 0);
    run_line(1, 1000, 700, 0, 0, $urandom, 0);
    run_line(1, 0, 0, 3, 10, $urandom, 0);
    run_line(1, 5, 5, 5, 5, 32'hCAFE0001, 0);
    run_line(1, 10, 20, 400, 90, $urandom, 2);
    run_line(1, 700, 30, 100, 300, $urandom, 3);
    run_line(1, 50, 60, 70, 900, 32'h12345678, 4);
    run_line(0, 50, 60, 70, 900, 32'h12345678, 0);

    for (int i = 0; i < 10; i++) begin
      run_line(1, $urandom_range(0, 1023), $urandom_range(0, 1023),
               $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom, (i % 2 == 0) ? 1 : 0);
    end

    // reset during a draw, then confirm the bus stays quiet and registers cleared
    run_line(1, 0, 0, 300, 200, 32'h00AA00BB, 5);
    repeat (10) tick();
    run_line(0, 0, 0, 0, 0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
